// File: rtl/mem_pkg.sv
// Host/device request-response types and error codes for memory endpoints.
package mem_pkg;
    import top_pkg::*;

    localparam int MEM_BW = MEM_DW / 8;

    localparam logic [1:0] ERR_CORR   = 2'b01;
    localparam logic [1:0] ERR_UNCORR = 2'b10;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] data;
        logic [MEM_BW-1:0] mask;
    } mem_h2d_t;

    typedef struct packed {
        logic              gnt;
        logic              valid;
        logic [MEM_DW-1:0] data;
        logic [1:0]        error;
    } mem_d2h_t;

    typedef struct packed {
        logic              valid;
        logic [MEM_DW-1:0] data;
        logic [1:0]        error;
    } mem_resp_t;
endpackage

// File: rtl/top_pkg.sv
// Global bus widths shared by every memory-side block.
package top_pkg;
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
endpackage

// File: rtl/mem_sram_responder_if.sv
// Bundles one host<->device memory link plus its error-injection side input.
interface mem_sram_responder_if;
    import mem_pkg::*;

    mem_h2d_t   h2d;
    mem_d2h_t   d2h;
    logic [1:0] err_inject;

    modport master (output h2d, output err_inject, input d2h);
    modport slave  (input h2d, input err_inject, output d2h);
endinterface

// File: rtl/mem_resp_pipe.sv
// Fixed-depth response delay line; stage 0 loads on the grant edge.
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  mem_resp_t in_i,
    output mem_resp_t out_o
);
    mem_resp_t r_stage [LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= in_i;
            for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign out_o = r_stage[LATENCY-1];
endmodule

// File: rtl/mem_sram_responder.sv
// Word-addressed SRAM endpoint with grant stalling, response latency and
// bad-address / injected error reporting.
module mem_sram_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 1,
    parameter int WAIT_STATES = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  mem_h2d_t   mem_i,
    output mem_d2h_t   mem_o,
    input  logic [1:0] err_inject_i
);
    localparam int OFF = $clog2(MEM_BW);
    localparam int IW  = top_pkg::MEM_AW - OFF;
    localparam int AW  = $clog2(DEPTH);

    logic [2:0]              r_wcnt;
    logic [top_pkg::MEM_DW-1:0] r_mem [DEPTH];

    logic          w_gnt;
    logic          w_mis;
    logic          w_oor;
    logic          w_bad;
    logic          w_wr;
    logic [IW-1:0] w_idx;
    logic [AW-1:0] w_waddr;
    mem_resp_t     w_resp_in;
    mem_resp_t     w_resp_out;

    assign w_idx   = mem_i.addr[top_pkg::MEM_AW-1:OFF];
    assign w_waddr = w_idx[AW-1:0];
    assign w_mis   = |mem_i.addr[OFF-1:0];
    assign w_oor   = (w_idx >= IW'(DEPTH));
    assign w_bad   = w_mis | w_oor;

    // Grant is combinational so zero wait states answer in the request cycle.
    assign w_gnt = mem_i.req && (r_wcnt == 3'(WAIT_STATES)) && !rst_i;
    assign w_wr  = w_gnt && mem_i.we && !w_bad;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wcnt <= '0;
        end else if (mem_i.req && !w_gnt) begin
            r_wcnt <= r_wcnt + 3'd1;
        end else begin
            r_wcnt <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            for (int b = 0; b < MEM_BW; b++) begin
                if (mem_i.mask[b]) r_mem[w_waddr][8*b +: 8] <= mem_i.data[8*b +: 8];
            end
        end
    end

    // Bad accesses and writes return zero data; only good reads see the array.
    always_comb begin
        w_resp_in = '0;
        if (w_gnt) begin
            w_resp_in.valid = 1'b1;
            w_resp_in.error = (w_bad ? ERR_UNCORR : 2'b00) | err_inject_i;
            if (!mem_i.we && !w_bad) w_resp_in.data = r_mem[w_waddr];
        end
    end

    mem_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (w_resp_in),
        .out_o (w_resp_out)
    );

    assign mem_o = '{
        gnt:   w_gnt,
        valid: w_resp_out.valid,
        data:  w_resp_out.data,
        error: w_resp_out.error
    };
endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed bench: four responder configurations sharing one clock and reset.
module tb_mem_sram_responder;
    import mem_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_sram_responder_if if0 ();
    mem_sram_responder_if if1 ();
    mem_sram_responder_if if2 ();
    mem_sram_responder_if if3 ();

    mem_sram_responder #(.DEPTH(1024), .LATENCY(1), .WAIT_STATES(0)) u0 (
        .clk_i(clk), .rst_i(rst), .mem_i(if0.h2d), .mem_o(if0.d2h),
        .err_inject_i(if0.err_inject));
    mem_sram_responder #(.DEPTH(1024), .LATENCY(1), .WAIT_STATES(3)) u1 (
        .clk_i(clk), .rst_i(rst), .mem_i(if1.h2d), .mem_o(if1.d2h),
        .err_inject_i(if1.err_inject));
    mem_sram_responder #(.DEPTH(1024), .LATENCY(3), .WAIT_STATES(0)) u2 (
        .clk_i(clk), .rst_i(rst), .mem_i(if2.h2d), .mem_o(if2.d2h),
        .err_inject_i(if2.err_inject));
    mem_sram_responder #(.DEPTH(1024), .LATENCY(4), .WAIT_STATES(0)) u3 (
        .clk_i(clk), .rst_i(rst), .mem_i(if3.h2d), .mem_o(if3.d2h),
        .err_inject_i(if3.err_inject));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic drv(input int u, input logic rq, input logic w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [1:0] inj);
        mem_h2d_t h;
        h = '{req: rq, we: w, addr: a, data: d, mask: m};
        case (u)
            0: begin if0.h2d = h; if0.err_inject = inj; end
            1: begin if1.h2d = h; if1.err_inject = inj; end
            2: begin if2.h2d = h; if2.err_inject = inj; end
            default: begin if3.h2d = h; if3.err_inject = inj; end
        endcase
    endtask

    function automatic logic [35:0] obs(input int u);
        case (u)
            0: return if0.d2h;
            1: return if1.d2h;
            2: return if2.d2h;
            default: return if3.d2h;
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        for (int u = 0; u < 4; u++) drv(u, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 2'b11);
        smp;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (obs(u) !== 36'h0) begin
                errors++;
                $display("FAIL reset_u%0d got %h exp %h", u, obs(u), 36'h0);
            end
        end
        nxt;
        rst = 1'b0;
        for (int u = 0; u < 4; u++) drv(u, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00);
        smp;
        for (int u = 0; u < 4; u++) begin
            checks++;
            if (obs(u) !== 36'h0) begin
                errors++;
                $display("FAIL release_u%0d got %h exp %h", u, obs(u), 36'h0);
            end
        end
    endtask

    task automatic test_masked_write;
        logic [0:4]  rq = 5'b11100;
        logic [0:4]  we = 5'b11000;
        logic [31:0] d  [5] = '{32'hDEADBEEF, 32'h11, 0, 0, 0};
        logic [3:0]  m  [5] = '{4'hF, 4'h1, 4'h0, 4'h0, 4'h0};
        logic [0:4]  eg = 5'b11100;
        logic [0:4]  ev = 5'b01110;
        logic [31:0] ed [5] = '{0, 0, 0, 32'hDEADBE11, 0};
        logic [35:0] exp;
        for (int k = 0; k < 5; k++) begin
            nxt;
            drv(0, rq[k], we[k], 32'h10, d[k], m[k], 2'b00);
            smp;
            exp = {eg[k], ev[k], ed[k], 2'b00};
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL masked_write[%0d] got %h exp %h", k, obs(0), exp);
            end
        end
    endtask

    task automatic test_wait_states;
        logic [0:14] rq = 15'b111101100111100;
        logic [0:14] we = 15'b111101100000000;
        logic [0:14] eg = 15'b000100000000100;
        logic [0:14] ev = 15'b000010000000010;
        logic [31:0] d;
        logic [31:0] ed;
        logic [35:0] exp;
        for (int k = 0; k < 15; k++) begin
            d  = (k < 4) ? 32'h55 : ((k == 5 || k == 6) ? 32'hAA : 32'h0);
            ed = (k == 13) ? 32'h55 : 32'h0;
            nxt;
            drv(1, rq[k], we[k], 32'h20, d, 4'hF, 2'b00);
            smp;
            exp = {eg[k], ev[k], ed, 2'b00};
            checks++;
            if (obs(1) !== exp) begin
                errors++;
                $display("FAIL wait_states[%0d] got %h exp %h", k, obs(1), exp);
            end
        end
    endtask

    task automatic test_pipelined;
        logic [35:0] exp;
        logic        v;
        for (int k = 0; k < 4; k++) begin
            nxt;
            drv(2, 1'b1, 1'b1, 32'(4 * k), 32'(k), 4'hF, 2'b00);
        end
        for (int k = 0; k < 4; k++) begin
            nxt;
            drv(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 2'b00);
        end
        for (int k = 0; k < 8; k++) begin
            nxt;
            drv(2, k < 4, 1'b0, 32'(4 * k), 32'h0, 4'h0, 2'b00);
            smp;
            v   = (k >= 3 && k <= 6);
            exp = {1'(k < 4), v, (v ? 32'(k - 3) : 32'h0), 2'b00};
            checks++;
            if (obs(2) !== exp) begin
                errors++;
                $display("FAIL pipelined[%0d] got %h exp %h", k, obs(2), exp);
            end
        end
    endtask

    task automatic test_bad;
        logic [0:5]  rq = 6'b111100;
        logic [0:5]  we = 6'b110000;
        logic [31:0] a  [6] = '{32'h0, 32'h1000, 32'h2, 32'h0, 0, 0};
        logic [31:0] d  [6] = '{32'h12345678, 32'hFFFFFFFF, 0, 0, 0, 0};
        logic [0:5]  eg = 6'b111100;
        logic [0:5]  ev = 6'b011110;
        logic [31:0] ed [6] = '{0, 0, 0, 0, 32'h12345678, 0};
        logic [1:0]  ee [6] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [35:0] exp;
        for (int k = 0; k < 6; k++) begin
            nxt;
            drv(0, rq[k], we[k], a[k], d[k], 4'hF, 2'b00);
            smp;
            exp = {eg[k], ev[k], ed[k], ee[k]};
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL bad_access[%0d] got %h exp %h", k, obs(0), exp);
            end
        end
    endtask

    task automatic test_inject;
        logic [0:4]  rq = 5'b10100;
        logic [31:0] a  [5] = '{32'h10, 0, 32'h2, 0, 0};
        logic [1:0]  ij [5] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0};
        logic [0:4]  eg = 5'b10100;
        logic [0:4]  ev = 5'b01010;
        logic [31:0] ed [5] = '{0, 32'hDEADBE11, 0, 0, 0};
        logic [1:0]  ee [5] = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
        logic [35:0] exp;
        for (int k = 0; k < 5; k++) begin
            nxt;
            drv(0, rq[k], 1'b0, a[k], 32'h0, 4'h0, ij[k]);
            smp;
            exp = {eg[k], ev[k], ed[k], ee[k]};
            checks++;
            if (obs(0) !== exp) begin
                errors++;
                $display("FAIL inject[%0d] got %h exp %h", k, obs(0), exp);
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic [0:17] rs = 18'b000000001000000000;
        logic [0:17] rq = 18'b100000101000010000;
        logic [0:17] we = 18'b100000000000000000;
        logic [0:17] eg = 18'b100000100000010000;
        logic [0:17] ev = 18'b000010000000000001;
        logic [31:0] ed;
        logic [35:0] exp;
        for (int k = 0; k < 18; k++) begin
            ed = (k == 17) ? 32'hCAFEF00D : 32'h0;
            nxt;
            rst = rs[k];
            drv(3, rq[k], we[k], 32'h30, 32'hCAFEF00D, 4'hF, 2'b00);
            smp;
            exp = {eg[k], ev[k], ed, 2'b00};
            checks++;
            if (obs(3) !== exp) begin
                errors++;
                $display("FAIL reset_midflight[%0d] got %h exp %h", k, obs(3), exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_masked_write;
        test_wait_states;
        test_pipelined;
        test_bad;
        test_inject;
        test_reset_midflight;
        nxt;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
